// File: rtl/div_pkg.sv
// div_pkg: shared types, widths and two's-complement helpers for the sequential signed divider
package div_pkg;
  localparam int DIV_WIDTH = 8;
  localparam int CNT_W = $clog2(DIV_WIDTH);
  typedef enum logic [1:0] {IDLE, DIV, FIX, DONE} state_t;
  function automatic logic [DIV_WIDTH-1:0] f_neg(input logic [DIV_WIDTH-1:0] x);
    return ~x + DIV_WIDTH'(1);
  endfunction
  function automatic logic [DIV_WIDTH-1:0] f_abs(input logic [DIV_WIDTH-1:0] x);
    return x[DIV_WIDTH-1] ? f_neg(x) : x;
  endfunction
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step (shift in a dividend bit, trial subtract)
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);
  logic [WIDTH:0] shifted, diff;
  always_comb begin
    shifted = {rem, bit_in};
    diff = shifted - {1'b0, divisor};
    q_bit = ~diff[WIDTH];
    rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end
endmodule

// File: rtl/signed_divider_8bit_seq.sv
// signed_divider_8bit_seq: iterative restoring signed divider with valid/ready handshakes
module signed_divider_8bit_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero,
  output logic             overflow
);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] pr, dq, bmag, rem_n, rmag;
  logic sign_q, sign_r, dz, ovf, q_bit, b_zero, accept;
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem(pr), .bit_in(dq[WIDTH-1]), .divisor(bmag), .rem_next(rem_n), .q_bit(q_bit)
  );
  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == DONE;
    b_zero = B == '0;
    accept = in_valid && in_ready;
    rmag = dz ? dq : pr;
    state_n = accept ? (b_zero ? FIX : DIV)
      : (state == DIV && cnt == '0) ? FIX
      : (state == FIX) ? DONE
      : (state == DONE && out_ready) ? IDLE : state;
  end
  // dq holds the shifting dividend and collects quotient bits from the right
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      pr <= '0;
      dq <= '0;
      bmag <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      dz <= 1'b0;
      ovf <= 1'b0;
      quotient <= '0;
      remainder <= '0;
      div_zero <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        dq <= f_abs(A);
        bmag <= f_abs(B);
        pr <= '0;
        sign_q <= A[WIDTH-1] ^ B[WIDTH-1];
        sign_r <= A[WIDTH-1];
        cnt <= CNT_W'(WIDTH - 1);
        dz <= b_zero;
        ovf <= A == {1'b1, {(WIDTH-1){1'b0}}} && B == '1;
        div_zero <= 1'b0;
        overflow <= 1'b0;
      end
      if (state == DIV) begin
        pr <= rem_n;
        dq <= {dq[WIDTH-2:0], q_bit};
        cnt <= cnt - 1'b1;
      end
      if (state == FIX) begin
        quotient <= dz ? '1 : (sign_q ? f_neg(dq) : dq);
        remainder <= sign_r ? f_neg(rmag) : rmag;
        div_zero <= dz;
        overflow <= ovf;
      end
    end
  end
endmodule
